// File: rtl/sd_host_cmd.sv
// Host-side SD CMD-line engine: SD clock divider, 48-bit command serialiser and
// 48/136-bit response deserialiser with CRC7 and end-bit checking.
module sd_host_cmd #(
    parameter int CLK_DIV = 2,
    parameter int TIMEOUT = 64
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [5:0]   i_cmd_index,
    input  logic [31:0]  i_cmd_arg,
    input  logic [1:0]   i_resp_type,
    output logic         o_busy,
    output logic         o_done,
    output logic [133:0] o_resp,
    output logic         o_crc_err,
    output logic         o_end_err,
    output logic         o_timeout,
    output logic         o_sd_clk,
    output logic         sd_cmd_o,
    output logic         sd_cmd_t,
    input  logic         sd_cmd_i
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    typedef enum logic [2:0] {IDLE, TX, WAIT, RX, GAP} state_t;

    state_t         state_q, state_d;
    logic [DW-1:0]  div_q, div_d;
    logic           sd_clk_q, sd_clk_d, cmd_o_q, cmd_o_d, cmd_t_q, cmd_t_d, done_q, done_d;
    logic           crc_err_q, crc_err_d, end_err_q, end_err_d, tout_q, tout_d;
    logic           has_resp_q, has_resp_d, long_q, long_d;
    logic [47:0]    frame_q, frame_d;
    logic [133:0]   rx_q, rx_d, resp_q, resp_d;
    logic [6:0]     crc_q, crc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           tick, fall_stb, rise_stb, last_bit, crc_cov;

    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = b ^ c[6];
        return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    function automatic logic [6:0] crc7_40(input logic [39:0] m);
        logic [6:0] c;
        c = '0;
        for (int i = 39; i >= 0; i--) c = crc7_step(c, m[i]);
        return c;
    endfunction

    assign tick     = (div_q == DW'(CLK_DIV - 1));
    assign fall_stb = tick & sd_clk_q;
    assign rise_stb = tick & ~sd_clk_q;
    // cnt counts bits received after the start bit; CRC spans frame bits 127:8 or 47:8
    assign last_bit = long_q ? (cnt_q == CW'(134)) : (cnt_q == CW'(46));
    assign crc_cov  = long_q ? (cnt_q >= CW'(7) && cnt_q <= CW'(126)) : (cnt_q <= CW'(38));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            div_q      <= '0;
            sd_clk_q   <= 1'b0;
            cmd_o_q    <= 1'b1;
            cmd_t_q    <= 1'b1;
            done_q     <= 1'b0;
            crc_err_q  <= 1'b0;
            end_err_q  <= 1'b0;
            tout_q     <= 1'b0;
            has_resp_q <= 1'b0;
            long_q     <= 1'b0;
            frame_q    <= '0;
            rx_q       <= '0;
            resp_q     <= '0;
            crc_q      <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            sd_clk_q   <= sd_clk_d;
            cmd_o_q    <= cmd_o_d;
            cmd_t_q    <= cmd_t_d;
            done_q     <= done_d;
            crc_err_q  <= crc_err_d;
            end_err_q  <= end_err_d;
            tout_q     <= tout_d;
            has_resp_q <= has_resp_d;
            long_q     <= long_d;
            frame_q    <= frame_d;
            rx_q       <= rx_d;
            resp_q     <= resp_d;
            crc_q      <= crc_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (i_start) state_d = TX;
            TX:   if (fall_stb && cnt_q == CW'(48)) state_d = has_resp_q ? WAIT : GAP;
            WAIT: if (rise_stb) begin
                      if (!sd_cmd_i) state_d = RX;
                      else if (cnt_q == CW'(TIMEOUT - 1)) state_d = GAP;
                  end
            RX:   if (rise_stb && last_bit) state_d = GAP;
            GAP:  if (rise_stb && cnt_q == CW'(7)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        div_d      = tick ? '0 : div_q + DW'(1);
        sd_clk_d   = tick ? ~sd_clk_q : sd_clk_q;
        cmd_o_d    = cmd_o_q;
        cmd_t_d    = cmd_t_q;
        done_d     = 1'b0;
        crc_err_d  = crc_err_q;
        end_err_d  = end_err_q;
        tout_d     = tout_q;
        has_resp_d = has_resp_q;
        long_d     = long_q;
        frame_d    = frame_q;
        rx_d       = rx_q;
        resp_d     = resp_q;
        crc_d      = crc_q;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE: if (i_start) begin
                      frame_d    = {2'b01, i_cmd_index, i_cmd_arg,
                                    crc7_40({2'b01, i_cmd_index, i_cmd_arg}), 1'b1};
                      has_resp_d = (i_resp_type == 2'd1) || (i_resp_type == 2'd2);
                      long_d     = (i_resp_type == 2'd2);
                      crc_err_d  = 1'b0;
                      end_err_d  = 1'b0;
                      tout_d     = 1'b0;
                      cnt_d      = '0;
                  end
            TX:   if (fall_stb) begin
                      if (cnt_q == CW'(48)) begin
                          cmd_t_d = 1'b1;
                          cmd_o_d = 1'b1;
                          cnt_d   = '0;
                          done_d  = ~has_resp_q;
                      end else begin
                          cmd_t_d = 1'b0;
                          cmd_o_d = frame_q[47];
                          frame_d = {frame_q[46:0], 1'b0};
                          cnt_d   = cnt_q + CW'(1);
                      end
                  end
            WAIT: if (rise_stb) begin
                      if (!sd_cmd_i) begin
                          cnt_d = '0;
                          rx_d  = '0;
                          crc_d = '0;
                      end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                          tout_d = 1'b1;
                          done_d = 1'b1;
                          cnt_d  = '0;
                      end else begin
                          cnt_d = cnt_q + CW'(1);
                      end
                  end
            RX:   if (rise_stb) begin
                      if (crc_cov) crc_d = crc7_step(crc_q, sd_cmd_i);
                      if (last_bit) begin
                          resp_d    = rx_q;
                          crc_err_d = (rx_q[6:0] != crc_q);
                          end_err_d = ~sd_cmd_i;
                          done_d    = 1'b1;
                          cnt_d     = '0;
                      end else begin
                          rx_d  = {rx_q[132:0], sd_cmd_i};
                          cnt_d = cnt_q + CW'(1);
                      end
                  end
            GAP:  if (rise_stb) cnt_d = cnt_q + CW'(1);
            default: ;
        endcase
    end

    assign o_busy    = (state_q != IDLE);
    assign o_done    = done_q;
    assign o_resp    = resp_q;
    assign o_crc_err = crc_err_q;
    assign o_end_err = end_err_q;
    assign o_timeout = tout_q;
    assign o_sd_clk  = sd_clk_q;
    assign sd_cmd_o  = cmd_o_q;
    assign sd_cmd_t  = cmd_t_q;

endmodule
